// File: rtl/common_pkg.sv
// Shared bus and register types used across the pipeline.
package common;

    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [7:0]  strobe_t;

    // Transfer size encoding: log2 of the byte count.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage payload types and the memory-stage state encoding.
package pipes;
    import common::*;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        LD  = 4'd3,
        SD  = 4'd4
    } decoded_op_t;

    typedef struct packed {
        decoded_op_t op;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        nop_signal;
    } control_t;

    typedef struct packed {
        addr_t      pc;
        control_t   ctl;
        word_t      result_alu;
        word_t      wd;
        creg_addr_t wa;
    } execute_data_t;

    typedef struct packed {
        addr_t      pc;
        control_t   ctl;
        word_t      result_alu;
        creg_addr_t wa;
        logic       addr_31;
    } memory_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // A bubble never touches memory, whatever its memread/memwrite bits say.
    function automatic logic is_nop(control_t c);
        return c.nop_signal || (c.op == NOP);
    endfunction

    function automatic logic is_mem_op(control_t c);
        return (c.memread || c.memwrite) && !is_nop(c);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: single-entry holding register with a data-bus FSM.
module mem_stage
    import common::*;
    import pipes::*;
#(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  execute_data_t in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output memory_data_t  out_data,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    input  logic          flush,
    output word_t         fwd_result,
    output creg_addr_t    fwd_wa,
    output logic          fwd_regwrite,
    output logic          busy,
    output logic          bus_err
);

    localparam logic [31:0] TimeoutLast = 32'(BUS_TIMEOUT - 1);

    mem_state_t   state;
    memory_data_t out_q;
    dbus_req_t    dreq_q;
    logic         discard;
    logic [31:0]  tcnt;

    logic         accept;
    logic         take_mem;
    memory_data_t in_latched;
    dbus_req_t    dreq_next;

    // Address-phase handshake is not needed: the request is held until data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp.addr_ok;

    // Input handshake and the values captured on accept.
    always_comb begin
        in_ready   = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
        accept     = in_valid && in_ready;
        take_mem   = is_mem_op(in_data.ctl);

        in_latched            = '0;
        in_latched.pc         = in_data.pc;
        in_latched.ctl        = in_data.ctl;
        in_latched.result_alu = in_data.result_alu;
        in_latched.wa         = in_data.wa;
        in_latched.addr_31    = in_data.result_alu[31];
        if (is_nop(in_data.ctl)) begin
            in_latched.ctl.regwrite = 1'b0;
        end

        dreq_next       = '0;
        dreq_next.valid = 1'b1;
        dreq_next.addr  = in_data.result_alu;
        dreq_next.size  = MSIZE8;
        if (in_data.ctl.memwrite) begin
            dreq_next.strobe = 8'hFF;
            dreq_next.data   = in_data.wd;
        end
    end

    // Stage FSM: accept, run the bus transaction, hold the result for writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            out_q   <= '0;
            dreq_q  <= '0;
            discard <= 1'b0;
            tcnt    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        out_q   <= in_latched;
                        discard <= 1'b0;
                        tcnt    <= '0;
                        if (take_mem) begin
                            dreq_q <= dreq_next;
                            state  <= BUSY;
                        end else begin
                            state  <= DONE;
                        end
                    end else if (flush || (state == IDLE) || out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    // A flush cannot abort the bus cycle, only its result.
                    discard <= discard || flush;
                    if (dresp.data_ok) begin
                        dreq_q  <= '0;
                        discard <= 1'b0;
                        if (out_q.ctl.memread) begin
                            out_q.result_alu <= dresp.data;
                        end
                        state <= (discard || flush) ? IDLE : DONE;
                    end else if ((BUS_TIMEOUT != 0) && (tcnt != BUS_TIMEOUT)) begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid    = (state == DONE);
    assign out_data     = out_q;
    assign dreq         = dreq_q;
    assign busy         = (state == BUSY);
    // Counter saturates at BUS_TIMEOUT, so this fires once per transaction.
    assign bus_err      = (BUS_TIMEOUT != 0) && (state == BUSY) && !dresp.data_ok &&
                          (tcnt == TimeoutLast);
    assign fwd_regwrite = out_valid && out_q.ctl.regwrite;
    assign fwd_result   = out_q.result_alu;
    assign fwd_wa       = out_q.wa;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// against a transaction-level model of the stage.
module tb_mem_stage;
    import common::*;
    import pipes::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    execute_data_t in_data;
    logic          out_ready;
    dbus_resp_t    dresp;
    logic          flush;

    logic          in_ready, out_valid, fwd_regwrite, busy, bus_err;
    memory_data_t  out_data;
    dbus_req_t     dreq;
    word_t         fwd_result;
    creg_addr_t    fwd_wa;

    logic          t_in_ready, t_out_valid, t_fwd_regwrite, t_busy, t_bus_err;
    memory_data_t  t_out_data;
    dbus_req_t     t_dreq;
    word_t         t_fwd_result;
    creg_addr_t    t_fwd_wa;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .dreq(dreq), .dresp(dresp), .flush(flush),
        .fwd_result(fwd_result), .fwd_wa(fwd_wa), .fwd_regwrite(fwd_regwrite),
        .busy(busy), .bus_err(bus_err)
    );

    mem_stage #(.BUS_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_data(in_data), .out_valid(t_out_valid), .out_ready(out_ready),
        .out_data(t_out_data), .dreq(t_dreq), .dresp(dresp), .flush(flush),
        .fwd_result(t_fwd_result), .fwd_wa(t_fwd_wa), .fwd_regwrite(t_fwd_regwrite),
        .busy(t_busy), .bus_err(t_bus_err)
    );

    function automatic execute_data_t mk_inst(decoded_op_t op, word_t alu, word_t wd,
                                              creg_addr_t wa, logic nop);
        execute_data_t e;
        e                = '0;
        e.pc             = 64'h0000_0000_0040_0000 + {57'd0, wa, 2'b00};
        e.ctl.op         = op;
        e.ctl.nop_signal = nop;
        e.result_alu     = alu;
        e.wd             = wd;
        e.wa             = wa;
        case (op)
            LD:      begin e.ctl.memread = 1'b1; e.ctl.regwrite = 1'b1; end
            SD:      e.ctl.memwrite = 1'b1;
            default: e.ctl.regwrite = 1'b1;
        endcase
        return e;
    endfunction

    // What writeback should see for an instruction, given the loaded word.
    function automatic memory_data_t expect_out(execute_data_t e, word_t ld_data);
        memory_data_t m;
        logic bubble;
        logic mem;
        bubble = e.ctl.nop_signal || (e.ctl.op == NOP);
        mem    = (e.ctl.memread || e.ctl.memwrite) && !bubble;
        m            = '0;
        m.pc         = e.pc;
        m.ctl        = e.ctl;
        m.wa         = e.wa;
        m.addr_31    = e.result_alu[31];
        m.result_alu = (mem && e.ctl.memread) ? ld_data : e.result_alu;
        if (bubble) m.ctl.regwrite = 1'b0;
        return m;
    endfunction

    // Leaves the bench at a falling edge with reset released and the DUT idle.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        dresp     = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (dreq !== '0) $display("FAIL reset_dreq: got %h want 0", dreq);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data);
        else n_pass++;
        n_checks++;
        if ({busy, bus_err, t_bus_err} !== 3'b000)
            $display("FAIL reset_busy_err: got %b want 000", {busy, bus_err, t_bus_err});
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        do_reset();
        in_data   = mk_inst(ADD, 64'h10, 64'h0, 5'd7, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data.result_alu !== 64'h10)
            $display("FAIL add_result: got v=%b r=%h want v=1 r=10", out_valid,
                     out_data.result_alu);
        else n_pass++;
        n_checks++;
        if (dreq.valid !== 1'b0) $display("FAIL add_no_dreq: got %b want 0", dreq.valid);
        else n_pass++;
        n_checks++;
        if (fwd_regwrite !== 1'b1 || fwd_result !== 64'h10 || fwd_wa !== 5'd7)
            $display("FAIL add_fwd: got %b %h %0d want 1 10 7", fwd_regwrite, fwd_result,
                     fwd_wa);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL add_drain: got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_ld();
        do_reset();
        in_data   = mk_inst(LD, 64'h8000_0008, 64'h0, 5'd3, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_checks++;
            if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_0008 || dreq.size !== MSIZE8 ||
                dreq.strobe !== 8'h00 || busy !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL ld_dreq_c%0d: got v=%b a=%h s=%0d st=%h busy=%b rdy=%b", k,
                         dreq.valid, dreq.addr, dreq.size, dreq.strobe, busy, in_ready);
            else n_pass++;
            if (k == 3) begin
                dresp.data_ok = 1'b1;
                dresp.data    = 64'h0000_0000_DEAD_BEEF;
            end
            @(negedge clk);
        end
        dresp = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data.result_alu !== 64'h0000_0000_DEAD_BEEF ||
            out_data.addr_31 !== 1'b1)
            $display("FAIL ld_result: got v=%b r=%h a31=%b want 1 deadbeef 1", out_valid,
                     out_data.result_alu, out_data.addr_31);
        else n_pass++;
        n_checks++;
        if (dreq.valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL ld_release: got v=%b busy=%b want 0 0", dreq.valid, busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_sd();
        do_reset();
        in_data   = mk_inst(SD, 64'h100, 64'h55, 5'd9, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (dreq.valid !== 1'b1 || dreq.addr !== 64'h100 || dreq.strobe !== 8'hFF ||
            dreq.data !== 64'h55 || out_valid !== 1'b0)
            $display("FAIL sd_dreq: got v=%b a=%h st=%h d=%h ov=%b", dreq.valid, dreq.addr,
                     dreq.strobe, dreq.data, out_valid);
        else n_pass++;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h1234;
        @(negedge clk);
        dresp = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data.result_alu !== 64'h100 ||
            out_data.ctl.regwrite !== 1'b0 || fwd_regwrite !== 1'b0)
            $display("FAIL sd_result: got v=%b r=%h rw=%b fwd=%b want 1 100 0 0", out_valid,
                     out_data.result_alu, out_data.ctl.regwrite, fwd_regwrite);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        word_t vals [4];
        vals[0] = 64'hA1; vals[1] = 64'hB2; vals[2] = 64'hC3; vals[3] = 64'hD4;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk_inst(ADD, vals[0], 64'h0, 5'd1, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            in_data = mk_inst(ADD, vals[i], 64'h0, 5'd1, 1'b0);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data.result_alu !== vals[i-1] || in_ready !== 1'b1)
                $display("FAIL b2b_%0d: got v=%b r=%h rdy=%b want 1 %h 1", i, out_valid,
                         out_data.result_alu, in_ready, vals[i-1]);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = mk_inst(ADD, vals[3], 64'h0, 5'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data.result_alu !== vals[2] || in_ready !== 1'b0)
                $display("FAIL b2b_hold_%0d: got v=%b r=%h rdy=%b want 1 %h 0", i, out_valid,
                         out_data.result_alu, in_ready, vals[2]);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data.result_alu !== vals[3])
            $display("FAIL b2b_resume: got v=%b r=%h want 1 %h", out_valid,
                     out_data.result_alu, vals[3]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_flush_busy();
        do_reset();
        out_ready = 1'b1;
        in_data   = mk_inst(LD, 64'h200, 64'h0, 5'd4, 1'b0);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        n_checks++;
        if (dreq.valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL flushb_c1: got v=%b rdy=%b want 1 0", dreq.valid, in_ready);
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            #1;
            n_checks++;
            if (dreq.valid !== 1'b1 || dreq.addr !== 64'h200 || out_valid !== 1'b0)
                $display("FAIL flushb_c%0d: got v=%b a=%h ov=%b", k, dreq.valid, dreq.addr,
                         out_valid);
            else n_pass++;
            if (k == 3) begin
                dresp.data_ok = 1'b1;
                dresp.data    = 64'h77;
            end
            @(negedge clk);
        end
        dresp = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || dreq.valid !== 1'b0)
                $display("FAIL flushb_after_%0d: got ov=%b busy=%b v=%b want 0 0 0", k,
                         out_valid, busy, dreq.valid);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_flush_done();
        do_reset();
        out_ready = 1'b0;
        in_data   = mk_inst(ADD, 64'h20, 64'h0, 5'd2, 1'b0);
        in_valid  = 1'b1;
        @(negedge clk);
        in_data = mk_inst(ADD, 64'h30, 64'h0, 5'd2, 1'b0);
        flush   = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL flushd_pri: got ov=%b rdy=%b want 1 0", out_valid, in_ready);
        else n_pass++;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flushd_drop: got %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        out_ready = 1'b1;
        in_data   = mk_inst(LD, 64'h300, 64'h0, 5'd5, 1'b0);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            if (t_bus_err === 1'b1) pulses++;
            n_checks++;
            if (t_bus_err !== (k == 4) || t_busy !== 1'b1 || bus_err !== 1'b0)
                $display("FAIL timeout_c%0d: got err=%b busy=%b err0=%b want %b 1 0", k,
                         t_bus_err, t_busy, bus_err, (k == 4));
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses != 1) $display("FAIL timeout_pulses: got %0d want 1", pulses);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (t_dreq.valid !== 1'b0 || t_busy !== 1'b0 || t_out_valid !== 1'b0 ||
            t_in_ready !== 1'b1 || dreq.valid !== 1'b0)
            $display("FAIL timeout_reset: got v=%b busy=%b ov=%b rdy=%b v0=%b", t_dreq.valid,
                     t_busy, t_out_valid, t_in_ready, dreq.valid);
        else n_pass++;
    endtask

    // Model: one in-flight memory op plus a queue of results awaiting writeback.
    task automatic test_random();
        execute_data_t inflight = '0;
        bit            have_inflight = 1'b0;
        int            wait_cnt = 0;
        memory_data_t  expq [$];
        logic          exp_ready;
        logic          ok;
        decoded_op_t   ops [5];
        ops[0] = NOP; ops[1] = ADD; ops[2] = SUB; ops[3] = LD; ops[4] = SD;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = mk_inst(ops[$urandom_range(0, 4)], {$urandom, $urandom},
                                {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                                ($urandom_range(0, 7) == 0));
            if (in_data.ctl.op == NOP) in_data.ctl.memread = 1'($urandom_range(0, 1));
            dresp = '0;
            if (have_inflight) begin
                if (wait_cnt == 0) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = {$urandom, $urandom};
                end else begin
                    wait_cnt--;
                end
            end
            #1;
            exp_ready = !have_inflight && ((expq.size() == 0) || out_ready);
            n_checks++;
            if (in_ready !== exp_ready || out_valid !== (expq.size() != 0) ||
                dreq.valid !== have_inflight)
                $display("FAIL rand_ctl_%0d: got rdy=%b ov=%b dv=%b want %b %b %b", cyc,
                         in_ready, out_valid, dreq.valid, exp_ready, (expq.size() != 0),
                         have_inflight);
            else n_pass++;
            if (have_inflight) begin
                ok = (dreq.addr === inflight.result_alu) && (dreq.size === MSIZE8) &&
                     (dreq.strobe === (inflight.ctl.memwrite ? 8'hFF : 8'h00));
                if (inflight.ctl.memwrite) ok = ok && (dreq.data === inflight.wd);
                n_checks++;
                if (!ok) $display("FAIL rand_dreq_%0d: got %h for addr %h", cyc, dreq,
                                  inflight.result_alu);
                else n_pass++;
            end
            if (expq.size() != 0) begin
                n_checks++;
                if (out_data !== expq[0] || fwd_regwrite !== expq[0].ctl.regwrite)
                    $display("FAIL rand_out_%0d: got %h want %h", cyc, out_data, expq[0]);
                else n_pass++;
            end
            if (expq.size() != 0 && out_ready) void'(expq.pop_front());
            if (have_inflight && dresp.data_ok) begin
                expq.push_back(expect_out(inflight, dresp.data));
                have_inflight = 1'b0;
            end else if (in_valid && exp_ready) begin
                if ((in_data.ctl.memread || in_data.ctl.memwrite) &&
                    !in_data.ctl.nop_signal && in_data.ctl.op != NOP) begin
                    inflight      = in_data;
                    have_inflight = 1'b1;
                    wait_cnt      = $urandom_range(0, 3);
                end else begin
                    expq.push_back(expect_out(in_data, 64'h0));
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        dresp    = '0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        dresp     = '0;
        flush     = 1'b0;
        test_reset();
        test_add();
        test_ld();
        test_sd();
        test_back_to_back();
        test_flush_busy();
        test_flush_done();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter BUS_TIMEOUT, default 0: cycles to wait for dresp.data_ok before flagging bus_err; 0 disables the timeout.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset; the design has one clock and this reset is synchronous and active-high.
REQ-004 in_valid  in  1  execute stage presents in_data.
REQ-005 in_ready  out  1  mem_stage accepts in_data this cycle.
REQ-006 in_data  in  execute_data_t  execute result (pc, ctl, result_alu, wd, wa).
REQ-007 out_valid  out  1  out_data valid for writeback.
REQ-008 out_ready  in  1  writeback consumes out_data this cycle.
REQ-009 out_data  out  memory_data_t  registered memory-stage result.
REQ-010 dreq  out  dbus_req_t  data bus request (valid, addr, size, strobe, data).
REQ-011 dresp  in  dbus_resp_t  data bus response (addr_ok, data_ok, data).
REQ-012 flush  in  1  discard the held instruction (branch/jump redirect).
REQ-013 fwd_result / fwd_wa / fwd_regwrite  out  word_t / creg_addr_t / 1  forwarding tap for decode.
REQ-014 busy  out  1  high while state is BUSY; upstream load-use stall.
REQ-015 bus_err  out  1  one-cycle pulse on timeout.

Function
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 Transfer in = in_valid && in_ready; in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-018 On transfer in: if ctl.memread or ctl.memwrite, latch in_data and go to BUSY; otherwise latch in_data and go to DONE (1-cycle latency).
REQ-019 BUSY: dreq.valid=1; addr=result_alu; size=8 bytes; LD: strobe=0; SD: strobe=8'hFF, data=wd; all dreq fields held stable until data_ok.
REQ-020 BUSY with dresp.data_ok: LD sets out_data.result_alu=dresp.data; SD keeps result_alu; next state DONE; dreq.valid deasserts the following cycle.
REQ-021 DONE: out_valid=1; out_ready with no transfer in leads to IDLE; out_ready with transfer in behaves per REQ-018 (back-to-back, no bubble).
REQ-022 out_data.addr_31 = result_alu[31] of the latched instruction, captured at accept.
REQ-023 ctl.nop_signal=1 or op==NOP: treated as non-memory; passes through with ctl.regwrite forced 0.
REQ-024 fwd_regwrite = out_valid && out_data.ctl.regwrite; fwd_result = out_data.result_alu; fwd_wa = out_data.wa.
REQ-025 flush in IDLE/DONE: next state IDLE and out_valid=0 next cycle; flush has priority over transfer in (in_ready=0 while flush is high).
REQ-026 flush in BUSY: bus transaction completes (never aborted); a sticky discard flag is set; on data_ok go to IDLE, out_valid never asserted for that instruction.
REQ-027 BUS_TIMEOUT>0: the counter resets on entry to BUSY; on reaching BUS_TIMEOUT without data_ok, pulse bus_err and stay in BUSY.
REQ-028 out_data is unchanged while out_valid && !out_ready.

Reset
REQ-029 On reset: state=IDLE, out_valid=0, out_data=0, dreq='0, discard=0, timeout counter=0, bus_err=0; reset mid-BUSY drops the transaction.

Structure
REQ-030 mem_state_t (IDLE/BUSY/DONE) is defined in package pipes alongside memory_data_t.
REQ-031 dbus_req_t/dbus_resp_t are used from common; the FSM is inline and no sub-module is warranted.

Verification
REQ-032 ADD, result_alu=0x10, out_ready=1 -> out_valid next cycle, result 0x10, no dreq.valid.
REQ-033 LD addr 0x80000008, data_ok after 3 cycles with data 0xDEADBEEF -> dreq stable 3 cycles, out_data.result_alu=0xDEADBEEF, addr_31=1.
REQ-034 SD addr 0x100, wd=0x55 -> strobe 0xFF, data 0x55, out_valid after data_ok, regwrite=0.
REQ-035 Three ADDs back-to-back with out_ready=1 -> one result per cycle; out_ready=0 for 2 cycles -> out_data held, in_ready=0.
REQ-036 flush during LD BUSY -> dreq stays until data_ok, then IDLE, out_valid never 1.
REQ-037 BUS_TIMEOUT=4, no data_ok -> bus_err pulses once at cycle 4 of BUSY; reset then yields IDLE with dreq.valid=0.
